pipeline_stage_skid: RTL and testbench

//  Parametrised pipeline stage register carrying PC, instruction and a control sideband between any two processor stages.

---
 rtl/pipeline_stage_skid.sv | 152 +++++++++++++++
 tb/tb_pipeline_stage_skid.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_skid.sv
// Pipeline stage register carrying PC, instruction and control sideband.
// Provides a valid/ready handshake, an optional 2-entry skid buffer,
// synchronous flush, and a saturating counter of downstream-starved cycles.
// An empty or flushed stage always presents the canonical bubble.
module pipeline_stage_skid #(
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        SIDE_W    = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
  parameter bit                 SKID      = 1'b1,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SIDE_W-1:0]  out_side,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SIDE_W-1:0]  side;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam beat_t BUBBLE = '{pc: '0, instr: NOP_INSTR, side: '0};

  state_t           state_q, state_d;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  beat_t            in_beat;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;

  assign in_beat  = '{pc: in_pc, instr: in_instr, side: in_side};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  // ready_q doubles as "out of reset" so the single-register variant also
  // holds in_ready low while reset is asserted.
  if (SKID) begin : g_skid
    assign in_ready = ready_q;
  end else begin : g_single
    assign in_ready = ready_q & (~valid_q | out_ready);
  end

  assign out_valid  = valid_q;
  assign out_pc     = main_q.pc;
  assign out_instr  = main_q.instr;
  assign out_side   = main_q.side;
  assign occupancy  = occ_q;
  assign bubble_cnt = cnt_q;

  // Next-state: FIFO order across main/skid, flush overrides, bubble on empty.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_beat;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_beat;
          end else if (in_fire && SKID) begin
            state_d = FULL;
            skid_d  = in_beat;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end

    valid_d = (state_d != EMPTY);
    ready_d = SKID ? (state_d != FULL) : 1'b1;

    case (state_d)
      ONE:     occ_d = 2'd1;
      FULL:    occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase

    cnt_d = cnt_q;
    if (out_ready && !valid_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      occ_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: scoreboard monitor on the skid build
// (plus a narrow-counter twin) and directed checks on a single-register build.
module tb_pipeline_stage_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_side = '0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_pc, a_out_instr, b_out_pc, b_out_instr;
  logic [7:0]  a_out_side, b_out_side;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  logic        c_in_valid = 1'b0;
  logic        c_out_ready = 1'b0;
  logic [31:0] c_in_pc = '0;
  logic [31:0] c_in_instr = '0;
  logic [7:0]  c_in_side = '0;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_pc, c_out_instr;
  logic [7:0]  c_out_side;
  logic [1:0]  c_occ;
  logic [15:0] c_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [71:0] sb[$];
  bit          mon_en = 1'b0;
  bit          rprev = 1'b1;
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;

  always #5 clock = ~clock;

  pipeline_stage_skid #(.SKID(1'b1), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .out_side(a_out_side),
    .occupancy(a_occ), .bubble_cnt(a_cnt));

  pipeline_stage_skid #(.SKID(1'b1), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .out_side(b_out_side),
    .occupancy(b_occ), .bubble_cnt(b_cnt));

  pipeline_stage_skid #(.SKID(1'b0), .CNT_W(16)) u_c (
    .clock(clock), .reset(reset), .flush(1'b0),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_pc(c_in_pc), .in_instr(c_in_instr), .in_side(c_in_side),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_pc(c_out_pc), .out_instr(c_out_instr), .out_side(c_out_side),
    .occupancy(c_occ), .bubble_cnt(c_cnt));

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Offers one beat and waits (bounded) until the skid DUT accepts it.
  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [7:0] side);
    bit ok;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    in_side  = side;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      ok = a_in_ready;
      @(posedge clock);
      #1;
      if (ok) return;
    end
    chk("push_timeout", 72'd0, 72'd1);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares DUT state against the queue model, then advances the
  // model by what happens at the coming edge.
  always @(negedge clock) begin : monitor
    logic        exp_v, exp_rdy;
    logic [71:0] fr;
    if (mon_en) begin
      exp_v   = (sb.size() != 0);
      exp_rdy = !rprev && (sb.size() < 2);
      chk("occupancy", 72'(a_occ), 72'(sb.size()));
      chk("b_occupancy", 72'(b_occ), 72'(sb.size()));
      chk("in_ready", 72'(a_in_ready), 72'(exp_rdy));
      chk("out_valid", 72'(a_out_valid), 72'(exp_v));
      chk("bubble_cnt", 72'(a_cnt), 72'(cnt_a));
      chk("b_bubble_cnt", 72'(b_cnt), 72'(cnt_b));
      if (exp_v) begin
        fr = sb[0];
        chk("out_beat", {a_out_pc, a_out_instr, a_out_side}, fr);
        chk("b_out_beat", {b_out_pc, b_out_instr, b_out_side}, fr);
      end else begin
        chk("bubble_out", {a_out_pc, a_out_instr, a_out_side}, {32'h0, NOP, 8'h0});
      end
      if (!reset) begin
        sb.delete();
        cnt_a = 0;
        cnt_b = 0;
      end else begin
        if (out_ready && !exp_v) begin
          if (cnt_a != 65535) cnt_a++;
          if (cnt_b != 3) cnt_b++;
        end
        if (exp_v && out_ready) void'(sb.pop_front());
        if (flush) sb.delete();
        else if (in_valid && exp_rdy) sb.push_back({in_pc, in_instr, in_side});
      end
      rprev = !reset;
    end
  end

  initial begin : stim
    bit          acc;
    logic [31:0] pcn;

    @(posedge clock);
    #1 mon_en = 1'b1;
    cycle();
    reset = 1'b1;

    // Idle counting and saturation of the 2-bit counter.
    repeat (5) cycle();
    chk("cnt_after_5", 72'(a_cnt), 72'd5);
    repeat (5) cycle();
    chk("cnt_after_10", 72'(a_cnt), 72'd10);
    chk("cnt_saturated", 72'(b_cnt), 72'd3);

    // One-cycle latency and one beat per cycle.
    push(32'h100, 32'h00500093, 8'h11);
    chk("t1_valid", 72'(a_out_valid), 72'd1);
    chk("t1_pc", 72'(a_out_pc), 72'h100);
    chk("t1_instr", 72'(a_out_instr), 72'h00500093);
    for (int i = 1; i < 4; i++) begin
      push(32'h100 + 32'(4 * i), 32'h00a00113 + 32'(i), 8'(i));
      chk("t1_stream_pc", 72'(a_out_pc), 72'(32'h100 + 32'(4 * i)));
    end
    in_valid = 1'b0;
    cycle();
    chk("t1_drained", 72'(a_out_valid), 72'd0);

    // Fill both entries under backpressure, then drain in order.
    out_ready = 1'b0;
    push(32'h200, 32'h11111111, 8'h20);
    push(32'h204, 32'h22222222, 8'h21);
    in_valid = 1'b1; in_pc = 32'h208; in_instr = 32'h33333333; in_side = 8'h22;
    cycle();
    chk("t2_occ_full", 72'(a_occ), 72'd2);
    chk("t2_in_ready_low", 72'(a_in_ready), 72'd0);
    chk("t2_held_pc", 72'(a_out_pc), 72'h200);
    out_ready = 1'b1;
    cycle();
    chk("t2_drain_pc1", 72'(a_out_pc), 72'h204);
    chk("t2_in_ready_back", 72'(a_in_ready), 72'd1);
    cycle();
    chk("t2_drain_pc2", 72'(a_out_pc), 72'h208);
    in_valid = 1'b0;
    cycle();
    chk("t2_empty", 72'(a_out_valid), 72'd0);

    // Flush from FULL with a beat offered.
    out_ready = 1'b0;
    push(32'h300, 32'h44444444, 8'h30);
    push(32'h304, 32'h55555555, 8'h31);
    in_valid = 1'b1; in_pc = 32'h308; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_valid", 72'(a_out_valid), 72'd0);
    chk("t3_instr", 72'(a_out_instr), 72'(NOP));
    chk("t3_pc", 72'(a_out_pc), 72'd0);
    chk("t3_occ", 72'(a_occ), 72'd0);
    chk("t3_in_ready", 72'(a_in_ready), 72'd1);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Flush discards a beat accepted in the same cycle.
    out_ready = 1'b0;
    push(32'h310, 32'h66666666, 8'h32);
    in_valid = 1'b1; in_pc = 32'h314; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3b_valid", 72'(a_out_valid), 72'd0);
    chk("t3b_occ", 72'(a_occ), 72'd0);

    // Flush together with out_fire: the presented beat completes.
    out_ready = 1'b1;
    push(32'h320, 32'h77777777, 8'h33);
    in_pc = 32'h324; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3c_valid", 72'(a_out_valid), 72'd0);
    repeat (2) cycle();

    // Reset while FULL.
    out_ready = 1'b0;
    push(32'h400, 32'h88888888, 8'h40);
    push(32'h404, 32'h99999999, 8'h41);
    in_valid = 1'b0;
    chk("t6_occ_before", 72'(a_occ), 72'd2);
    reset = 1'b0;
    cycle();
    chk("t6_valid", 72'(a_out_valid), 72'd0);
    chk("t6_occ", 72'(a_occ), 72'd0);
    chk("t6_in_ready", 72'(a_in_ready), 72'd0);
    chk("t6_cnt", 72'(a_cnt), 72'd0);
    chk("t6_out", {a_out_pc, a_out_instr, a_out_side}, {32'h0, NOP, 8'h0});
    reset = 1'b1;
    cycle();
    chk("t6_in_ready_release", 72'(a_in_ready), 72'd1);

    // Random valid/ready/flush traffic against the scoreboard.
    pcn = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      acc = in_valid && a_in_ready;
      cycle();
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = pcn;
        pcn      = pcn + 32'd4;
        in_instr = $urandom;
        in_side  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();

    // Single-register build: combinational in_ready and back-to-back transfer.
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_pc = 32'h500; c_in_instr = 32'h0aa00093; c_in_side = 8'h50;
    #1 chk("t5_ready_empty", 72'(c_in_ready), 72'd1);
    cycle();
    chk("t5_first_pc", 72'(c_out_pc), 72'h500);
    c_in_pc = 32'h504; c_in_instr = 32'h0bb00093;
    #1 chk("t5_ready_held", 72'(c_in_ready), 72'd0);
    c_out_ready = 1'b1;
    #1 chk("t5_ready_comb", 72'(c_in_ready), 72'd1);
    cycle();
    chk("t5_b2b_pc", 72'(c_out_pc), 72'h504);
    c_in_pc = 32'h508; c_in_instr = 32'h0cc00093;
    cycle();
    chk("t5_b2b_pc2", 72'(c_out_pc), 72'h508);
    chk("t5_occ", 72'(c_occ), 72'd1);
    c_in_valid = 1'b0;
    cycle();
    chk("t5_empty", 72'(c_out_valid), 72'd0);
    chk("t5_bubble", 72'(c_out_instr), 72'(NOP));

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
